// File: rtl/eth_frame_log_pkg.sv
// eth_frame_log_pkg
// Shared definitions for the frame-log packer and the extractor that feeds it.
// The control-record field offsets live here so that both sides agree on one
// record layout.
//   CTL_*_LSB    : bit offsets of TIMESTAMP / NUMBER / SIZE / MATCHED in the record
//   FLAG_OVERFLOW: bit of the header flags byte set when no script matched
//   log_state_t  : packer FSM states
package eth_frame_log_pkg;

    localparam int CTL_TS_LSB    = 0;
    localparam int CTL_NUM_LSB   = 64;
    localparam int CTL_SIZE_LSB  = 96;
    localparam int CTL_MATCH_LSB = 112;
    localparam int CTL_W         = 120;

    localparam int LOG_W         = 64;
    localparam int KEEP_W        = LOG_W / 8;
    localparam int WORDS_W       = 14;

    localparam int FLAG_OVERFLOW = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_TS   = 2'd2,
        ST_DATA = 2'd3
    } log_state_t;

    // Payload words for a byte count; 17-bit sum so 65535 bytes yields 8192.
    function automatic logic [WORDS_W-1:0] size_to_words(input logic [15:0] size);
        return WORDS_W'(({1'b0, size} + 17'd7) >> 3);
    endfunction

    // Byte-enable for the final payload word given SIZE[2:0].
    function automatic logic [KEEP_W-1:0] tail_keep(input logic [2:0] rem);
        if (rem == 3'd0) begin
            return 8'hFF;
        end
        return 8'hFF >> (4'd8 - {1'b0, rem});
    endfunction

endpackage

// File: rtl/eth_frame_log_packer_if.sv
// eth_frame_log_packer_if
// Stream bundle around the frame-log packer.
//   s_axis_ctl_*   : 120-bit control records from the extraction FIFO
//   s_axis_frame_* : 64-bit packed payload words from the extraction FIFO
//   m_axis_*       : framed log entries towards the log DMA/mux
// Modports:
//   master : environment side (drives records and payload, drives m_axis_tready)
//   slave  : packer side
interface eth_frame_log_packer_if;
    import eth_frame_log_pkg::*;

    logic [CTL_W-1:0]  s_axis_ctl_tdata;
    logic              s_axis_ctl_tvalid;
    logic              s_axis_ctl_tready;

    logic [LOG_W-1:0]  s_axis_frame_tdata;
    logic              s_axis_frame_tvalid;
    logic              s_axis_frame_tready;

    logic [LOG_W-1:0]  m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;

    modport master (
        output s_axis_ctl_tdata, s_axis_ctl_tvalid,
        input  s_axis_ctl_tready,
        output s_axis_frame_tdata, s_axis_frame_tvalid,
        input  s_axis_frame_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_ctl_tdata, s_axis_ctl_tvalid,
        output s_axis_ctl_tready,
        input  s_axis_frame_tdata, s_axis_frame_tvalid,
        output s_axis_frame_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

endinterface

// File: rtl/eth_frame_log_packer.sv
// eth_frame_log_packer
// Pops one control record plus its payload words and emits one log entry:
// header word, timestamp word, then payload, tkeep trimmed on the final word.
// Ports:
//   clk, srst        : log clock, synchronous active-high reset
//   enable           : gates the start of new entries only
//   bus (slave)      : ctl record in, payload in, log entry out
//   entries_logged   : completed entries (wraps)
//   overflow_entries : completed entries whose MATCHED was zero (wraps)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a record; may still be draining the last word
// ST_HDR  | header word held in the output register
// ST_TS   | timestamp held; pulls the first payload word if any remain
// ST_DATA | payload word held; pulls the next one until words_left hits 0
module eth_frame_log_packer
    import eth_frame_log_pkg::*;
#(
    parameter int         C_NUM_SCRIPTS    = 4,
    parameter int         C_AXIS_LOG_WIDTH = 64,
    parameter logic [7:0] C_SOURCE_ID      = 8'd0
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       enable,
    eth_frame_log_packer_if.slave      bus,
    output logic [31:0]                entries_logged,
    output logic [31:0]                overflow_entries
);

    localparam int         KEEP_BYTES = C_AXIS_LOG_WIDTH / 8;
    localparam logic [7:0] MATCH_MASK = 8'hFF >> (8 - C_NUM_SCRIPTS);

    log_state_t                  state_q, state_d;
    logic [63:0]                 ts_q, ts_d;
    logic [2:0]                  size_lo_q, size_lo_d;
    logic                        ovf_q, ovf_d;
    logic [WORDS_W-1:0]          words_left_q, words_left_d;
    logic [C_AXIS_LOG_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_BYTES-1:0]       out_keep_q, out_keep_d;
    logic                        out_last_q, out_last_d;
    logic                        out_valid_q, out_valid_d;
    logic [31:0]                 entries_q, entries_d;
    logic [31:0]                 ovf_cnt_q, ovf_cnt_d;

    logic        advance;
    logic        ctl_rdy;
    logic        frame_rdy;
    logic [7:0]  in_matched;
    logic [7:0]  in_flags;
    logic [15:0] in_size;
    logic [31:0] in_number;
    logic [63:0] in_ts;

    assign in_ts      = bus.s_axis_ctl_tdata[CTL_TS_LSB    +: 64];
    assign in_number  = bus.s_axis_ctl_tdata[CTL_NUM_LSB   +: 32];
    assign in_size    = bus.s_axis_ctl_tdata[CTL_SIZE_LSB  +: 16];
    assign in_matched = bus.s_axis_ctl_tdata[CTL_MATCH_LSB +: 8] & MATCH_MASK;

    always_comb begin
        in_flags                = {C_SOURCE_ID[3:0], 4'b0000};
        in_flags[FLAG_OVERFLOW] = (in_matched == 8'd0);
    end

    // Output register may take a new word when empty or being consumed.
    assign advance = !out_valid_q || bus.m_axis_tready;

    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q;
        size_lo_d    = size_lo_q;
        ovf_d        = ovf_q;
        words_left_d = words_left_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        entries_d    = entries_q;
        ovf_cnt_d    = ovf_cnt_q;
        ctl_rdy      = 1'b0;
        frame_rdy    = 1'b0;

        // Word consumed (or register empty): drop valid unless reloaded below.
        if (advance) begin
            out_valid_d = 1'b0;
        end

        // ovf_q still belongs to the entry in flight: a new record cannot be
        // latched until the final word has left the output register.
        if (out_valid_q && bus.m_axis_tready && out_last_q) begin
            entries_d = entries_q + 32'd1;
            if (ovf_q) begin
                ovf_cnt_d = ovf_cnt_q + 32'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                ctl_rdy = enable && !out_valid_q && !srst;
                if (ctl_rdy && bus.s_axis_ctl_tvalid) begin
                    ts_d         = in_ts;
                    size_lo_d    = in_size[2:0];
                    ovf_d        = in_flags[FLAG_OVERFLOW];
                    words_left_d = size_to_words(in_size);
                    out_data_d   = {in_matched, in_flags, in_size, in_number};
                    out_keep_d   = '1;
                    out_last_d   = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                if (advance) begin
                    out_data_d  = ts_q;
                    out_keep_d  = '1;
                    out_last_d  = (words_left_q == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_TS;
                end
            end
            ST_TS, ST_DATA: begin
                if (words_left_q == '0) begin
                    // Empty entry: timestamp was the last word.
                    if (advance) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    frame_rdy = advance && !srst;
                    if (frame_rdy && bus.s_axis_frame_tvalid) begin
                        out_data_d   = bus.s_axis_frame_tdata;
                        out_valid_d  = 1'b1;
                        words_left_d = words_left_q - 1'b1;
                        if (words_left_q == WORDS_W'(1)) begin
                            out_last_d = 1'b1;
                            out_keep_d = tail_keep(size_lo_q);
                            state_d    = ST_IDLE;
                        end else begin
                            out_last_d = 1'b0;
                            out_keep_d = '1;
                            state_d    = ST_DATA;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            ts_q         <= '0;
            size_lo_q    <= '0;
            ovf_q        <= 1'b0;
            words_left_q <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            entries_q    <= '0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            size_lo_q    <= size_lo_d;
            ovf_q        <= ovf_d;
            words_left_q <= words_left_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            entries_q    <= entries_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign bus.s_axis_ctl_tready   = ctl_rdy;
    assign bus.s_axis_frame_tready = frame_rdy;
    assign bus.m_axis_tdata        = out_data_q;
    assign bus.m_axis_tkeep        = out_keep_q;
    assign bus.m_axis_tlast        = out_last_q;
    assign bus.m_axis_tvalid       = out_valid_q;
    assign entries_logged          = entries_q;
    assign overflow_entries        = ovf_cnt_q;

endmodule
